// File: rtl/data_memory_banked.sv
// Banked byte-addressed data memory: RV32I load/store widths, registered reads, two-beat split of word-crossing accesses.
// Latency 1 cycle (2 for split accesses); req_ready drops during the second beat, responses are never backpressured.
module data_memory_banked #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataWr,
  input  logic [2:0]        DMCtrl,
  input  logic              DMWr,
  output logic              rsp_valid,
  output logic [31:0]       DataRd,
  output logic              err
);
  localparam int BYTE_AW = $clog2(DEPTH_BYTES);
  localparam int WORD_AW = BYTE_AW - 2;
  localparam int WORDS   = DEPTH_BYTES / 4;

  typedef enum logic {IDLE, BEAT2} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]         w_mask;
  logic [1:0]         w_size_m1;
  logic               w_ctrl_ok;
  logic [7:0]         w_be;
  logic [63:0]        w_wdat;
  logic [ADDR_W:0]    w_end;
  logic               w_cross, w_err, w_accept;
  logic [WORD_AW-1:0] w_widx, w_addr;
  logic [3:0]         w_we;
  logic [7:0]         w_wbyte [4];

  logic               r_rsp_vld, r_err, r_store;
  logic [1:0]         r_off;
  logic [2:0]         r_ctrl;
  logic [WORD_AW-1:0] r_widx;
  logic [3:0]         r_be_hi;
  logic [31:0]        r_wdat_hi;
  logic [7:0]         r_lo [4];
  logic [7:0]         r_hi [4];
  logic [31:0]        w_raw, w_fmt;

  always_comb begin
    w_ctrl_ok = 1'b1;
    w_mask    = 4'b0000;
    w_size_m1 = 2'd0;
    case (DMCtrl)
      3'b000, 3'b100: begin w_mask = 4'b0001; w_size_m1 = 2'd0; end
      3'b001, 3'b101: begin w_mask = 4'b0011; w_size_m1 = 2'd1; end
      3'b010:         begin w_mask = 4'b1111; w_size_m1 = 2'd3; end
      default:        w_ctrl_ok = 1'b0;
    endcase
  end

  // Lane enables and store data are laid out over two adjacent words; bits [7:4] / [63:32] belong to the upper word.
  assign w_be     = {4'b0000, w_mask} << Address[1:0];
  assign w_wdat   = {32'd0, DataWr} << {Address[1:0], 3'b000};
  assign w_cross  = |w_be[7:4];
  assign w_end    = {1'b0, Address} + {{(ADDR_W-1){1'b0}}, w_size_m1};
  assign w_err    = !w_ctrl_ok || (DMWr && DMCtrl[2]) ||
                    (w_end >= (ADDR_W+1)'(DEPTH_BYTES)) || (w_cross && !MISALIGN_EN);
  assign w_widx   = Address[BYTE_AW-1:2];
  assign w_accept = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        if (w_accept && w_cross && !w_err) w_state_nxt = BEAT2;
      end
      BEAT2:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rsp_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rsp_vld <= (w_accept && !(w_cross && !w_err)) || (r_state == BEAT2);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_err     <= w_err;
      r_store   <= DMWr;
      r_off     <= Address[1:0];
      r_ctrl    <= DMCtrl;
      r_widx    <= w_widx;
      r_be_hi   <= w_be[7:4];
      r_wdat_hi <= w_wdat[63:32];
    end
  end

  // Upper-word writes are suppressed if reset lands on the second beat.
  always_comb begin
    w_addr = (r_state == BEAT2) ? r_widx + WORD_AW'(1) : w_widx;
    for (int k = 0; k < 4; k++) begin
      if (r_state == BEAT2) begin
        w_we[k]    = !rst && r_store && r_be_hi[k];
        w_wbyte[k] = r_wdat_hi[8*k +: 8];
      end else begin
        w_we[k]    = w_accept && DMWr && !w_err && w_be[k];
        w_wbyte[k] = w_wdat[8*k +: 8];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] r_mem [WORDS];
    always_ff @(posedge clk) begin
      if (w_we[k]) r_mem[w_addr] <= w_wbyte[k];
      if (w_accept) r_lo[k] <= r_mem[w_addr];
      else if (r_state == BEAT2) r_hi[k] <= r_mem[w_addr];
    end
  end

  assign w_raw = 32'({r_hi[3], r_hi[2], r_hi[1], r_hi[0], r_lo[3], r_lo[2], r_lo[1], r_lo[0]}
                     >> {r_off, 3'b000});

  always_comb begin
    case (r_ctrl)
      3'b000:  w_fmt = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_fmt = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_fmt = {24'd0, w_raw[7:0]};
      3'b101:  w_fmt = {16'd0, w_raw[15:0]};
      default: w_fmt = w_raw;
    endcase
  end

  assign rsp_valid = r_rsp_vld;
  assign err       = r_rsp_vld && r_err;
  assign DataRd    = (r_rsp_vld && !r_err && !r_store) ? w_fmt : 32'd0;
endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench: dut_a splits word-crossing accesses, dut_b rejects them.
module tb_data_memory_banked;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_a = 1'b0, vld_b = 1'b0;
  logic        rdy_a, rdy_b, rsp_a, rsp_b, err_a, err_b;
  logic [31:0] addr = '0, wdat = '0, rd_a, rd_b;
  logic [2:0]  ctrl = '0;
  logic        wr = 1'b0;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  data_memory_banked #(.DEPTH_BYTES(1024), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(vld_a), .req_ready(rdy_a), .Address(addr),
    .DataWr(wdat), .DMCtrl(ctrl), .DMWr(wr), .rsp_valid(rsp_a), .DataRd(rd_a), .err(err_a));

  data_memory_banked #(.DEPTH_BYTES(1024), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld_b), .req_ready(rdy_b), .Address(addr),
    .DataWr(wdat), .DMCtrl(ctrl), .DMWr(wr), .rsp_valid(rsp_b), .DataRd(rd_b), .err(err_b));

  typedef struct {
    bit          sel;
    bit          st;
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    bit          exp_rdy1;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response; lat=0 means no response seen.
  task automatic xact(input bit sel, input bit st, input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd_o, output logic e_o,
                      output int lat_o, output logic rdy1_o);
    bit acc = 1'b0;
    rd_o = '0; e_o = 1'b0; lat_o = 0; rdy1_o = 1'b0;
    addr = a; wdat = d; ctrl = c; wr = st;
    if (sel) vld_b = 1'b1; else vld_a = 1'b1;
    for (int i = 0; i < 5 && !acc; i++) begin
      @(negedge clk);
      acc = sel ? rdy_b : rdy_a;
      @(posedge clk);
    end
    #1 vld_a = 1'b0; vld_b = 1'b0;
    if (acc) begin
      for (int l = 1; l <= 4; l++) begin
        @(negedge clk);
        if (l == 1) rdy1_o = sel ? rdy_b : rdy_a;
        if (sel ? rsp_b : rsp_a) begin
          lat_o = l;
          rd_o  = sel ? rd_b : rd_a;
          e_o   = sel ? err_b : err_a;
          break;
        end
      end
      @(posedge clk); #1;
    end else begin
      n_chk++; n_fail++;
      $display("FAIL accept timeout: got req_ready=0 expected 1");
    end
  endtask

  logic [31:0] rd;
  logic        e, r1;
  int          lat;
  logic [31:0] bb_exp [4];

  initial begin
    //            sel st  ctrl    addr        wdata         exp_rd        err lat rdy1
    vecs[0]  = '{0, 1, 3'b010, 32'h010, 32'h800000F1, 32'h00000000, 0, 1, 1};
    vecs[1]  = '{0, 0, 3'b000, 32'h010, 32'h0,        32'hFFFFFFF1, 0, 1, 1};
    vecs[2]  = '{0, 0, 3'b100, 32'h010, 32'h0,        32'h000000F1, 0, 1, 1};
    vecs[3]  = '{0, 0, 3'b001, 32'h012, 32'h0,        32'hFFFF8000, 0, 1, 1};
    vecs[4]  = '{0, 0, 3'b101, 32'h012, 32'h0,        32'h00008000, 0, 1, 1};
    vecs[5]  = '{0, 1, 3'b010, 32'h00E, 32'hAABBCCDD, 32'h00000000, 0, 2, 0};
    vecs[6]  = '{0, 0, 3'b010, 32'h00E, 32'h0,        32'hAABBCCDD, 0, 2, 0};
    vecs[7]  = '{0, 0, 3'b100, 32'h011, 32'h0,        32'h000000AA, 0, 1, 1};
    vecs[8]  = '{0, 0, 3'b001, 32'h00F, 32'h0,        32'hFFFFBBCC, 0, 2, 0};
    vecs[9]  = '{1, 1, 3'b010, 32'h00C, 32'hCAFEBABE, 32'h00000000, 0, 1, 1};
    vecs[10] = '{1, 1, 3'b010, 32'h00E, 32'h12345678, 32'h00000000, 1, 1, 1};
    vecs[11] = '{1, 0, 3'b010, 32'h00C, 32'h0,        32'hCAFEBABE, 0, 1, 1};
    vecs[12] = '{0, 1, 3'b000, 32'h000, 32'h0000005A, 32'h00000000, 0, 1, 1};
    vecs[13] = '{0, 0, 3'b010, 32'h3FE, 32'h0,        32'h00000000, 1, 1, 1};
    vecs[14] = '{0, 1, 3'b000, 32'h400, 32'h00000055, 32'h00000000, 1, 1, 1};
    vecs[15] = '{0, 0, 3'b100, 32'h000, 32'h0,        32'h0000005A, 0, 1, 1};
    vecs[16] = '{0, 1, 3'b010, 32'h3FC, 32'h01020304, 32'h00000000, 0, 1, 1};
    vecs[17] = '{0, 0, 3'b010, 32'h3FC, 32'h0,        32'h01020304, 0, 1, 1};
    vecs[18] = '{0, 0, 3'b101, 32'h3FE, 32'h0,        32'h00000102, 0, 1, 1};
    vecs[19] = '{0, 0, 3'b001, 32'h3FF, 32'h0,        32'h00000000, 1, 1, 1};
    vecs[20] = '{0, 1, 3'b010, 32'h020, 32'h13579BDF, 32'h00000000, 0, 1, 1};
    vecs[21] = '{0, 0, 3'b011, 32'h020, 32'h0,        32'h00000000, 1, 1, 1};
    vecs[22] = '{0, 1, 3'b101, 32'h020, 32'h0000FFFF, 32'h00000000, 1, 1, 1};
    vecs[23] = '{0, 0, 3'b010, 32'h020, 32'h0,        32'h13579BDF, 0, 1, 1};
    bb_exp = '{32'hDF, 32'h9B, 32'h57, 32'h13};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'd0, rdy_a}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_a}, 32'd0);
    chk("reset err", {31'd0, err_a}, 32'd0);
    chk("reset DataRd", rd_a, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", {31'd0, rdy_a}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].sel, vecs[i].st, vecs[i].c, vecs[i].a, vecs[i].d, rd, e, lat, r1);
      chk($sformatf("v%0d DataRd", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d req_ready after accept", i), {31'd0, r1}, {31'd0, vecs[i].exp_rdy1});
    end

    // Back-to-back LBU with req_valid held: one response per cycle.
    ctrl = 3'b100; wr = 1'b0; vld_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h20 + i;
      @(negedge clk);
      chk($sformatf("b2b%0d req_ready", i), {31'd0, rdy_a}, 32'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d rsp_valid", i), {31'd0, rsp_a}, 32'd1);
        chk($sformatf("b2b%0d DataRd", i), rd_a, bb_exp[i-1]);
      end
      @(posedge clk); #1;
    end
    vld_a = 1'b0;
    @(negedge clk);
    chk("b2b last rsp_valid", {31'd0, rsp_a}, 32'd1);
    chk("b2b last DataRd", rd_a, bb_exp[3]);
    @(posedge clk); #1;

    // Reset landing on the second beat of a split store.
    xact(0, 1, 3'b010, 32'h00C, 32'h0, rd, e, lat, r1);
    chk("zero 0x0C latency", lat, 1);
    xact(0, 1, 3'b010, 32'h010, 32'h0, rd, e, lat, r1);
    chk("zero 0x10 latency", lat, 1);
    addr = 32'h00E; wdat = 32'h11223344; ctrl = 3'b010; wr = 1'b1; vld_a = 1'b1;
    @(negedge clk);
    chk("split store ready", {31'd0, rdy_a}, 32'd1);
    @(posedge clk); #1 vld_a = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("beat2 rsp_valid", {31'd0, rsp_a}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort%0d rsp_valid", i), {31'd0, rsp_a}, 32'd0);
      chk($sformatf("abort%0d err", i), {31'd0, err_a}, 32'd0);
      chk($sformatf("abort%0d DataRd", i), rd_a, 32'd0);
      @(posedge clk); #1;
    end
    xact(0, 0, 3'b010, 32'h00C, 32'h0, rd, e, lat, r1);
    chk("abort LW 0x0C", rd, 32'h33440000);
    chk("abort LW 0x0C latency", lat, 1);
    xact(0, 0, 3'b010, 32'h010, 32'h0, rd, e, lat, r1);
    chk("abort LW 0x10", rd, 32'h00000000);
    chk("abort LW 0x10 latency", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
